// File: rtl/bloom_hash_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bloom_pkg: shared constants and helpers for the Bloom hash arbiter.
//   CRC32_POLY / CRC32_INIT : CRC-32 constants (MSB-first, no final XOR).
//   calc_id_w()             : requester ID width, max(1, clog2(n)).
//   crc32_byte()            : one-byte CRC update used by every CRC user.
// -----------------------------------------------------------------------------
package bloom_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  function automatic int calc_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Byte enters at the top of the register; bit 7 is shifted in first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {data, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/bloom_hash_arbiter_if.sv
// -----------------------------------------------------------------------------
// bloom_hash_arbiter_if: request and result buses of the Bloom hash arbiter.
//   req_valid_i / req_data_i / req_ready_o : per-requester window handshake
//   res_valid_o / res_ready_i              : result handshake
//   res_id_o / res_crc_o / res_addr_o      : result payload
//   res_cnt_o                              : delivered-result counter
// master drives requests and result backpressure; slave is the arbiter.
// -----------------------------------------------------------------------------
interface bloom_hash_arbiter_if
  import bloom_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BYTES_CNT = 15,
  parameter int ADDR_W    = 12
);
  localparam int ID_W = calc_id_w(NUM_REQ);

  logic [NUM_REQ-1:0]                  req_valid_i;
  logic [NUM_REQ-1:0][BYTES_CNT*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]                  req_ready_o;
  logic                                res_valid_o;
  logic                                res_ready_i;
  logic [ID_W-1:0]                     res_id_o;
  logic [31:0]                         res_crc_o;
  logic [ADDR_W-1:0]                   res_addr_o;
  logic [31:0]                         res_cnt_o;

  modport master (
    output req_valid_i, req_data_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_id_o, res_crc_o, res_addr_o, res_cnt_o
  );

  modport slave (
    input  req_valid_i, req_data_i, res_ready_i,
    output req_ready_o, res_valid_o, res_id_o, res_crc_o, res_addr_o, res_cnt_o
  );

endinterface

// File: rtl/bloom_hash_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin grant.
//   i_valid : per-requester valid
//   i_ptr   : requester index where the search starts (always < NUM_REQ)
//   o_grant : one-hot grant of the first valid requester at or after i_ptr,
//             searching upward with wrap-around; zero when nothing is valid.
// -----------------------------------------------------------------------------
module rr_arbiter
  import bloom_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             i_valid,
  input  logic [calc_id_w(NUM_REQ)-1:0]  i_ptr,
  output logic [NUM_REQ-1:0]             o_grant
);
  localparam int ID_W = calc_id_w(NUM_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // NOTE: every variable written here gets a default first, so no path
  // through the loop can leave one unassigned and infer a latch.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so ptr + k cannot overflow before the wrap.
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bloom_hash_arbiter.sv
// -----------------------------------------------------------------------------
// bloom_hash_arbiter: NUM_REQ requesters share one CRC-32 hash unit.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : bloom_hash_arbiter_if.slave (request/result handshakes, counter)
// A round-robin grant feeds a two-stage elastic pipeline: S1 holds the
// granted window and ID, S2 holds the CRC, Bloom address and ID. Ready
// propagates backwards combinationally, so one window per cycle is
// sustained and at most two windows are in flight under backpressure.
// -----------------------------------------------------------------------------
module bloom_hash_arbiter
  import bloom_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BYTES_CNT = 15,
  parameter int ADDR_W    = 12
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  bloom_hash_arbiter_if.slave bus
);
  localparam int ID_W  = calc_id_w(NUM_REQ);
  localparam int WIN_W = BYTES_CNT * 8;

  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_s1_valid;
  logic [WIN_W-1:0]   r_s1_data;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_s2_valid;
  logic [ID_W-1:0]    r_s2_id;
  logic [31:0]        r_s2_crc;
  logic [ADDR_W-1:0]  r_s2_addr;
  logic [31:0]        r_res_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [ID_W-1:0]    w_gidx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_hs;
  logic               w_s1_ready;
  logic               w_s2_ready;
  logic               w_res_fire;
  logic [31:0]        w_crc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_valid (bus.req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign w_s2_ready = !r_s2_valid || bus.res_ready_i;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign w_res_fire = r_s2_valid && bus.res_ready_i;

  // Reset gates ready directly so nothing is accepted while held in reset.
  assign w_req_ready = w_grant & {NUM_REQ{w_s1_ready & rst_n_i}};
  assign w_hs        = |(bus.req_valid_i & w_req_ready);

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gidx = ID_W'(i);
    end
    w_ptr_nxt = (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + ID_W'(1);
  end

  // CRC over the S1 window, byte 0 first.
  always_comb begin
    w_crc = CRC32_INIT;
    for (int b = 0; b < BYTES_CNT; b++) begin
      w_crc = crc32_byte(w_crc, r_s1_data[b*8 +: 8]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_crc   <= '0;
      r_s2_addr  <= '0;
      r_res_cnt  <= '0;
    end else begin
      if (w_hs) r_rr_ptr <= w_ptr_nxt;
      if (w_s1_ready) r_s1_valid <= w_hs;
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_id   <= r_s1_id;
          r_s2_crc  <= w_crc;
          r_s2_addr <= w_crc[ADDR_W-1:0];
        end
      end
      if (w_res_fire) r_res_cnt <= r_res_cnt + 32'd1;
    end
  end

  // NOTE: S1 payload is qualified by r_s1_valid, so it carries no reset;
  // only control state and the visible outputs are cleared.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_s1_data <= bus.req_data_i[w_gidx];
      r_s1_id   <= w_gidx;
    end
  end

  assign bus.req_ready_o = w_req_ready;
  assign bus.res_valid_o = r_s2_valid;
  assign bus.res_id_o    = r_s2_id;
  assign bus.res_crc_o   = r_s2_crc;
  assign bus.res_addr_o  = r_s2_addr;
  assign bus.res_cnt_o   = r_res_cnt;

endmodule

// File: tb/tb_bloom_hash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bloom_hash_arbiter: self-checking bench for bloom_hash_arbiter.
// A reference model keeps the in-flight windows as a queue of
// {id, crc, age}; a window is visible at the output once it has aged one
// edge and is the oldest in flight, and a new window is accepted when
// fewer than two are in flight or the oldest is leaving this edge.
// -----------------------------------------------------------------------------
module tb_bloom_hash_arbiter;

  localparam int NR    = 4;
  localparam int BC    = 15;
  localparam int AW    = 12;
  localparam int WIN_W = BC * 8;

  typedef logic [NR-1:0][WIN_W-1:0] win_t;
  typedef struct {
    int          id;
    logic [31:0] crc;
    int          age;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bloom_hash_arbiter_if #(.NUM_REQ(NR), .BYTES_CNT(BC), .ADDR_W(AW)) bus ();

  bloom_hash_arbiter #(.NUM_REQ(NR), .BYTES_CNT(BC), .ADDR_W(AW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  item_t       q[$];
  int          m_ptr = 0;
  logic [31:0] m_cnt = '0;
  int          last_hs_id;
  int          hs_total = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-32: feedback = crc[31] xor data bit, bit 7 of each byte first.
  function automatic logic [31:0] ref_crc(input logic [WIN_W-1:0] w);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int b = 0; b < BC; b++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[31] ^ w[b*8+k];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return c;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < BC; b++) w[r][b*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  function automatic bit head_out();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  task automatic check_outputs();
    check("res_valid", bus.res_valid_o, head_out());
    if (head_out()) begin
      check("res_id", bus.res_id_o, q[0].id);
      check("res_crc", bus.res_crc_o, q[0].crc);
      check("res_addr", bus.res_addr_o, q[0].crc[AW-1:0]);
    end
    check("res_cnt", bus.res_cnt_o, m_cnt);
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic [NR-1:0] v, input win_t d, input logic rr);
    int             g;
    logic [NR-1:0]  exp_rdy;
    bit             pop;
    bit             push;
    check_outputs();
    bus.req_valid_i = v;
    bus.req_data_i  = d;
    bus.res_ready_i = rr;
    #1;
    g       = pick(v, m_ptr);
    exp_rdy = '0;
    push    = 1'b0;
    if (g >= 0 && (q.size() < 2 || rr)) begin
      exp_rdy[g] = 1'b1;
      push       = 1'b1;
    end
    check("req_ready", bus.req_ready_o, exp_rdy);
    last_hs_id = -1;
    for (int i = 0; i < NR; i++)
      if (bus.req_valid_i[i] && bus.req_ready_o[i]) last_hs_id = i;
    if (last_hs_id >= 0) hs_total++;
    pop = head_out() && rr;
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    foreach (q[i]) q[i].age++;
    if (push) begin
      q.push_back('{id: g, crc: ref_crc(d[g]), age: 0});
      m_ptr = (g + 1) % NR;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, rand_win(), 1'b1);
  endtask

  // Asynchronous reset between edges, with every requester asking for service.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.req_valid_i = '1;
    #1;
    check("rst_valid", bus.res_valid_o, 1'b0);
    check("rst_cnt", bus.res_cnt_o, 32'd0);
    check("rst_id", bus.res_id_o, '0);
    check("rst_crc", bus.res_crc_o, 32'd0);
    check("rst_addr", bus.res_addr_o, '0);
    check("rst_ready", bus.req_ready_o, '0);
    q.delete();
    m_ptr = 0;
    m_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready_hold", bus.req_ready_o, '0);
    check("rst_ptr", dut.r_rr_ptr, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w;
    int   n_hs;

    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.res_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Single window from requester 0, bytes 0x00..0x0E.
    w = rand_win();
    for (int b = 0; b < BC; b++) w[0][b*8 +: 8] = 8'(b);
    cycle(4'b0001, w, 1'b1);
    check("lat_not_yet", bus.res_valid_o, 1'b0);
    cycle(4'b0000, rand_win(), 1'b1);
    check("lat_valid", bus.res_valid_o, 1'b1);
    check("lat_id", bus.res_id_o, 0);
    check("lat_crc", bus.res_crc_o, ref_crc(w[0]));
    check("lat_addr", bus.res_addr_o, ref_crc(w[0]) & 32'hFFF);
    cycle(4'b0000, rand_win(), 1'b1);
    check("lat_cnt", bus.res_cnt_o, 32'd1);

    // All requesters valid for 8 cycles: strict rotation, one per cycle.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, rand_win(), 1'b1);
      check("rr_order", last_hs_id, k % NR);
    end
    idle(3);
    check("rr_all_delivered", bus.res_cnt_o, 32'd8);

    // Requesters 1 and 3 with the pointer at 2.
    do_reset();
    cycle(4'b0010, rand_win(), 1'b1);
    check("ptr_at_2", dut.r_rr_ptr, 2);
    cycle(4'b1010, rand_win(), 1'b1);
    check("grant_3_first", last_hs_id, 3);
    cycle(4'b1010, rand_win(), 1'b1);
    check("grant_1_next", last_hs_id, 1);
    check("ptr_ends_2", dut.r_rr_ptr, 2);
    idle(3);

    // Backpressure: continuous requests, result side stalled for 5 cycles.
    n_hs = hs_total;
    for (int k = 0; k < 5; k++) cycle(4'b1111, rand_win(), 1'b0);
    check("bp_accepted", hs_total - n_hs, 2);
    check("bp_ready_low", bus.req_ready_o, '0);
    n_hs = int'(bus.res_cnt_o);
    idle(4);
    check("bp_drained", int'(bus.res_cnt_o) - n_hs, 2);

    // Reset with two windows in flight, then a request from requester 2.
    cycle(4'b0001, rand_win(), 1'b0);
    cycle(4'b0010, rand_win(), 1'b0);
    check("two_in_flight", q.size(), 2);
    do_reset();
    cycle(4'b0100, rand_win(), 1'b1);
    cycle(4'b0000, rand_win(), 1'b1);
    check("post_rst_valid", bus.res_valid_o, 1'b1);
    check("post_rst_id", bus.res_id_o, 2);
    idle(2);

    // Counter wrap.
    force dut.r_res_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_res_cnt;
    m_cnt = 32'hFFFFFFFF;
    check("cnt_preload", bus.res_cnt_o, 32'hFFFFFFFF);
    cycle(4'b1000, rand_win(), 1'b1);
    idle(2);
    check("cnt_wrap", bus.res_cnt_o, 32'd0);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++)
      cycle(4'($urandom), rand_win(), ($urandom_range(0, 3) != 0));
    idle(4);
    check("final_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
